rom_stream_reader: RTL and testbench



---
 rtl/rom_stream_reader_pkg.sv | 20 ++
 rtl/rom_stream_fifo.sv | 67 ++++++
 rtl/rom_stream_reader.sv | 139 +++++++++++++
 tb/tb_rom_stream_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_reader_pkg.sv
// Shared types and defaults for the ROM stream reader: FSM state encoding,
// default geometry and the FIFO occupancy-counter width helper.
package rom_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_ADDR_BITS  = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Width able to hold every occupancy value 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rom_stream_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on head_data
// whenever count is non-zero. Pop on an empty FIFO is ignored.
module rom_stream_fifo
  import rom_stream_reader_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push)   wr_d = nxt(wr_q);
    if (pop_ok) rd_d = nxt(rd_q);
    unique case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates validity, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign head_data = mem_q[rd_q];
  assign count     = count_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Burst sequencer driving a sync-read ROM; credit-limited issue into an FWFT FIFO.
// Optional macro ROM_STREAM_READER_LAST_EN adds io_out_last marking each burst's final word.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_cmd_valid,
  output logic                  io_cmd_ready,
  input  logic [ADDR_BITS-1:0]  io_cmd_base,
  input  logic [ADDR_BITS:0]    io_cmd_len,
  output logic [ADDR_BITS-1:0]  io_rom_addr,
  output logic                  io_rom_en,
  input  logic [DATA_WIDTH-1:0] io_rom_data,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [DATA_WIDTH-1:0] io_out_data,
  output logic                  io_busy,
  output logic                  io_done
`ifdef ROM_STREAM_READER_LAST_EN
  ,
  output logic                  io_out_last
`endif
);

  localparam int CW = cnt_w(FIFO_DEPTH);
`ifdef ROM_STREAM_READER_LAST_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif
  localparam logic [CW:0]        DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS:0] ONE_C   = (ADDR_BITS + 1)'(1);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [ADDR_BITS:0]     rem_q, rem_d;
  logic                   inflight_q, done_q, done_d;
  logic [CW-1:0]          fifo_count;
  logic [CW:0]            credit_used;
  logic [FW-1:0]          fifo_in, fifo_head;
  logic                   issue, fifo_pop;

  // Words in the FIFO plus the one still inside the ROM must never exceed FIFO_DEPTH.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue       = (state_q == ST_RUN) && (rem_q != '0) && (credit_used < DEPTH_C);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (io_cmd_valid) begin
          if (io_cmd_len != '0) begin
            addr_d  = io_cmd_base;
            rem_d   = io_cmd_len;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == ONE_C) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (fifo_count == '0)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
      done_q     <= done_d;
    end
  end

`ifdef ROM_STREAM_READER_LAST_EN
  logic last_inflight_q;

  always_ff @(posedge clock) begin
    if (reset) last_inflight_q <= 1'b0;
    else       last_inflight_q <= issue && (rem_q == ONE_C);
  end

  assign fifo_in     = {last_inflight_q, io_rom_data};
  assign io_out_last = fifo_head[DATA_WIDTH] & io_out_valid;
`else
  assign fifo_in = io_rom_data;
`endif

  rom_stream_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign fifo_pop     = io_out_valid & io_out_ready;
  assign io_out_valid = (fifo_count != '0);
  assign io_out_data  = fifo_head[DATA_WIDTH-1:0];
  assign io_cmd_ready = (state_q == ST_IDLE);
  assign io_busy      = (state_q != ST_IDLE);
  assign io_done      = done_q;
  assign io_rom_en    = issue;
  assign io_rom_addr  = addr_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader against a sync ROM holding mem[i]=3*i+1.
// Expected streams come from burst arithmetic on (base, len), not from the RTL structure.
module tb_rom_stream_reader;

  localparam int AB = 4;
  localparam int DW = 8;
  localparam int FD = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_cmd_valid = 1'b0;
  logic          io_cmd_ready;
  logic [AB-1:0] io_cmd_base = '0;
  logic [AB:0]   io_cmd_len = '0;
  logic [AB-1:0] io_rom_addr;
  logic          io_rom_en;
  logic [DW-1:0] io_rom_data = '0;
  logic          io_out_valid;
  logic          io_out_ready = 1'b0;
  logic [DW-1:0] io_out_data;
  logic          io_busy;
  logic          io_done;
`ifdef ROM_STREAM_READER_LAST_EN
  logic          io_out_last;
`endif

  rom_stream_reader #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_cmd_valid (io_cmd_valid),
    .io_cmd_ready (io_cmd_ready),
    .io_cmd_base  (io_cmd_base),
    .io_cmd_len   (io_cmd_len),
    .io_rom_addr  (io_rom_addr),
    .io_rom_en    (io_rom_en),
    .io_rom_data  (io_rom_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_data  (io_out_data),
    .io_busy      (io_busy),
    .io_done      (io_done)
`ifdef ROM_STREAM_READER_LAST_EN
    ,
    .io_out_last  (io_out_last)
`endif
  );

  always #5 clock = ~clock;

  logic [DW-1:0] rom_mem [1 << AB];
  initial for (int i = 0; i < (1 << AB); i++) rom_mem[i] = DW'(3 * i + 1);

  always @(posedge clock) if (io_rom_en) io_rom_data <= rom_mem[io_rom_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_count = 0;
  int done_count = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int            pop_cyc_q[$];
  logic [AB-1:0] en_addr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every accepted output word must be the next expected one.
  always @(negedge clock) begin
    if (!reset) begin
      if (io_rom_en) begin
        en_count++;
        en_addr_q.push_back(io_rom_addr);
      end
      if (io_out_valid && io_out_ready) begin
        pop_cyc_q.push_back(cyc);
        check("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("out_data", 32'(io_out_data), 32'(exp_q.pop_front()));
`ifdef ROM_STREAM_READER_LAST_EN
          check("out_last", 32'(io_out_last), 32'(exp_last_q.pop_front()));
`else
          void'(exp_last_q.pop_front());
`endif
        end
      end
      if (io_done) begin
        done_count++;
        check("busy_low_at_done", 32'(io_busy), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one burst, waits for io_done, then checks issue addresses, drain and pulse width.
  task automatic run_burst(input int base, input int len, input int ready_pct,
                           input int hold, output int acc_cyc, output int en_at_hold);
    int n, en0, d0, busy_low;
    n = 0;
    while (!io_cmd_ready && n < 100) begin step(); n++; end
    check("cmd_ready_wait", 32'(io_cmd_ready), 1);
    io_cmd_valid = 1'b1;
    io_cmd_base  = AB'(base);
    io_cmd_len   = (AB + 1)'(len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(rom_mem[(base + i) % (1 << AB)]);
      exp_last_q.push_back(i == len - 1);
    end
    en_addr_q.delete();
    pop_cyc_q.delete();
    en0 = en_count;
    d0  = done_count;
    en_at_hold = 0;
    io_out_ready = (hold == 0) && ($urandom_range(99) < ready_pct);
    acc_cyc = cyc + 1;
    step();
    io_cmd_valid = 1'b0;
    if (len == 0) check("zero_len_done_next", 32'(io_done), 1);
    n = 0;
    busy_low = 0;
    while (!io_done && n < 2000) begin
      if (!io_busy) busy_low++;
      if (n == hold) en_at_hold = en_count - en0;
      io_out_ready = (n >= hold) && ($urandom_range(99) < ready_pct);
      step();
      n++;
    end
    check("done_seen", 32'(io_done), 1);
    check("busy_during_burst", busy_low, 0);
    check("issue_count", en_count - en0, len);
    check("exp_drained", exp_q.size(), 0);
    for (int i = 0; i < en_addr_q.size(); i++)
      check("rom_addr_seq", 32'(en_addr_q[i]), 32'((base + i) % (1 << AB)));
    step();
    check("done_pulse_once", done_count - d0, 1);
    check("done_one_cycle", 32'(io_done), 0);
  endtask

  initial begin
    int acc, eh, n, en0, d0;
    step();
    step();
    check("rst_cmd_ready", 32'(io_cmd_ready), 1);
    check("rst_rom_en", 32'(io_rom_en), 0);
    check("rst_rom_addr", 32'(io_rom_addr), 0);
    check("rst_out_valid", 32'(io_out_valid), 0);
    check("rst_busy", 32'(io_busy), 0);
    check("rst_done", 32'(io_done), 0);
    reset = 1'b0;
    step();

    // Basic burst: 7,10,13,16 back to back, first word two cycles after accept.
    run_burst(2, 4, 100, 0, acc, eh);
    check("basic_pops", pop_cyc_q.size(), 4);
    if (pop_cyc_q.size() == 4) begin
      check("first_word_latency", pop_cyc_q[0] - acc, 2);
      for (int i = 1; i < 4; i++) check("consecutive_words", pop_cyc_q[i] - pop_cyc_q[0], i);
    end

    run_burst(14, 4, 100, 0, acc, eh);

    // Backpressure: only FIFO_DEPTH issues while ready is held low.
    run_burst(0, 8, 100, 10, acc, eh);
    check("backpressure_issues", eh, FD);

    run_burst(9, 0, 100, 0, acc, eh);

    // Command held valid during a full-length burst must be refused until io_done.
    n = 0;
    while (!io_cmd_ready && n < 100) begin step(); n++; end
    io_cmd_valid = 1'b1;
    io_cmd_base  = AB'(3);
    io_cmd_len   = (AB + 1)'(16);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(rom_mem[(3 + i) % (1 << AB)]);
      exp_last_q.push_back(i == 15);
    end
    io_out_ready = 1'b1;
    step();
    en0 = 0;
    n = 0;
    while (!io_done && n < 500) begin
      if (io_cmd_ready) en0++;
      io_out_ready = ($urandom_range(99) < 70);
      step();
      n++;
    end
    io_cmd_valid = 1'b0;
    check("cmd_blocked_while_busy", en0, 0);
    check("long_burst_done", 32'(io_done), 1);
    check("long_burst_drained", exp_q.size(), 0);
    step();

    // Mid-burst reset one cycle after the third issue.
    io_cmd_valid = 1'b1;
    io_cmd_base  = '0;
    io_cmd_len   = (AB + 1)'(10);
    io_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(rom_mem[i]);
      exp_last_q.push_back(i == 9);
    end
    en0 = en_count;
    step();
    io_cmd_valid = 1'b0;
    n = 0;
    while ((en_count - en0) < 3 && n < 50) begin step(); n++; end
    reset = 1'b1;
    step();
    check("mid_rst_out_valid", 32'(io_out_valid), 0);
    check("mid_rst_busy", 32'(io_busy), 0);
    check("mid_rst_done", 32'(io_done), 0);
    reset = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    d0 = done_count;
    for (int i = 0; i < 5; i++) step();
    check("mid_rst_no_done", done_count - d0, 0);
    check("mid_rst_idle_valid", 32'(io_out_valid), 0);
    run_burst(5, 1, 100, 0, acc, eh);

    run_burst(0, 3, 100, 0, acc, eh);

    for (int k = 0; k < 25; k++)
      run_burst(int'($urandom_range(15)), int'($urandom_range(16)),
                int'($urandom_range(100, 20)), int'($urandom_range(3)), acc, eh);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
